// File: rtl/serial_mag_cmp_if.sv
// rtl/serial_mag_cmp_if.sv - operand/result handshake bundle for serial_mag_cmp
interface serial_mag_cmp_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] P;
  logic [WIDTH-1:0] Q;
  logic             out_valid;
  logic             out_ready;
  logic             PGTQ;
  logic             PEQQ;
  logic             PLTQ;

  modport master (
    output in_valid, P, Q, out_ready,
    input  in_ready, out_valid, PGTQ, PEQQ, PLTQ
  );

  modport slave (
    input  in_valid, P, Q, out_ready,
    output in_ready, out_valid, PGTQ, PEQQ, PLTQ
  );
endinterface

// File: rtl/serial_mag_cmp.sv
// rtl/serial_mag_cmp.sv - bit-serial MSB-first magnitude comparator, early exit at first differing bit
// Define SERIAL_MAG_CMP_SIGNED_EN for two's complement operands.
module serial_mag_cmp #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_mag_cmp_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] p_sr;
  logic [WIDTH-1:0] q_sr;
  logic [CW-1:0]    cnt;
  logic             pgtq;
  logic             peqq;
  logic             pltq;

  logic p_msb;
  logic q_msb;
  logic sign_step;
  logic bit_gt;
  logic bit_lt;

  assign p_msb = p_sr[WIDTH-1];
  assign q_msb = q_sr[WIDTH-1];

`ifdef SERIAL_MAG_CMP_SIGNED_EN
  // The sign bit is only ever examined on the first step, while cnt is still at its load value.
  assign sign_step = (cnt == CW'(WIDTH - 1));
`else
  assign sign_step = 1'b0;
`endif

  assign bit_gt = sign_step ? (~p_msb & q_msb) : (p_msb & ~q_msb);
  assign bit_lt = sign_step ? (p_msb & ~q_msb) : (~p_msb & q_msb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      p_sr  <= '0;
      q_sr  <= '0;
      cnt   <= '0;
      pgtq  <= 1'b0;
      peqq  <= 1'b0;
      pltq  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            p_sr  <= bus.P;
            q_sr  <= bus.Q;
            cnt   <= CW'(WIDTH - 1);
            state <= S_CMP;
          end
        end
        S_CMP: begin
          if (p_msb != q_msb) begin
            pgtq  <= bit_gt;
            pltq  <= bit_lt;
            state <= S_DONE;
          end else if (cnt == '0) begin
            peqq  <= 1'b1;
            state <= S_DONE;
          end else begin
            p_sr <= {p_sr[WIDTH-2:0], 1'b0};
            q_sr <= {q_sr[WIDTH-2:0], 1'b0};
            cnt  <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            pgtq  <= 1'b0;
            peqq  <= 1'b0;
            pltq  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.PGTQ      = pgtq;
  assign bus.PEQQ      = peqq;
  assign bus.PLTQ      = pltq;
endmodule

// File: tb/tb_serial_mag_cmp.sv
// tb/tb_serial_mag_cmp.sv - scoreboard bench for serial_mag_cmp (honours SERIAL_MAG_CMP_SIGNED_EN)
module tb_serial_mag_cmp;
  localparam int W = 8;

  logic clk;
  logic rst_n;

  serial_mag_cmp_if #(.WIDTH(W)) bus ();

  serial_mag_cmp #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] flags;  // {gt, eq, lt}
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks;
  int   n_fail;

  function automatic logic [2:0] model_flags(input logic [W-1:0] p, input logic [W-1:0] q);
`ifdef SERIAL_MAG_CMP_SIGNED_EN
    if ($signed(p) > $signed(q)) return 3'b100;
    if ($signed(p) < $signed(q)) return 3'b001;
`else
    if (p > q) return 3'b100;
    if (p < q) return 3'b001;
`endif
    return 3'b010;
  endfunction

  function automatic int model_lat(input logic [W-1:0] p, input logic [W-1:0] q);
    logic [W-1:0] x;
    x = p ^ q;
    for (int i = W - 1; i >= 0; i--)
      if (x[i]) return W - i;
    return W;
  endfunction

  task automatic run_cmp(input logic [W-1:0] p, input logic [W-1:0] q, input bit early, input int hold);
    exp_t       e;
    int         lat;
    logic [2:0] obs;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_ready p=%h q=%h in_ready=%b required 1", p, q, bus.in_ready);
    end
    bus.P = p;
    bus.Q = q;
    bus.in_valid = 1'b1;
    e.flags = model_flags(p, q);
    e.lat   = model_lat(p, q);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.P         = ~p;
    bus.Q         = ~q;
    bus.out_ready = early;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 2 * W) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    e   = sb.pop_front();
    obs = {bus.PGTQ, bus.PEQQ, bus.PLTQ};
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL result_timeout p=%h q=%h out_valid=%b required 1", p, q, bus.out_valid);
    end
    n_checks++;
    if (lat !== e.lat) begin
      n_fail++;
      $display("FAIL latency p=%h q=%h got %0d required %0d", p, q, lat, e.lat);
    end
    n_checks++;
    if (obs !== e.flags) begin
      n_fail++;
      $display("FAIL flags p=%h q=%h got %b required %b", p, q, obs, e.flags);
    end
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.P = W'($urandom);
      bus.Q = W'($urandom);
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1 || {bus.PGTQ, bus.PEQQ, bus.PLTQ} !== e.flags || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable cycle=%0d out_valid=%b flags=%b in_ready=%b required 1 %b 0",
                 i, bus.out_valid, {bus.PGTQ, bus.PEQQ, bus.PLTQ}, bus.in_ready, e.flags);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || {bus.PGTQ, bus.PEQQ, bus.PLTQ} !== 3'b000 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL after_handshake out_valid=%b flags=%b in_ready=%b required 0 000 1",
               bus.out_valid, {bus.PGTQ, bus.PEQQ, bus.PLTQ}, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.P = '0;
    bus.Q = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || {bus.PGTQ, bus.PEQQ, bus.PLTQ} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_state in_ready=%b out_valid=%b flags=%b required 1 0 000",
               bus.in_ready, bus.out_valid, {bus.PGTQ, bus.PEQQ, bus.PLTQ});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_cmp(8'hA5, 8'hA5, 1'b0, 0);
    run_cmp(8'h80, 8'h7F, 1'b0, 0);
    run_cmp(8'h34, 8'h3C, 1'b0, 0);
    run_cmp(8'h00, 8'h00, 1'b0, 0);
    run_cmp(8'h7F, 8'h80, 1'b0, 0);
    run_cmp(8'hFF, 8'hFE, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    run_cmp(8'h12, 8'h13, 1'b0, 0);
    run_cmp(8'hFF, 8'h00, 1'b0, 0);
    run_cmp(8'h40, 8'h41, 1'b1, 0);
    run_cmp(8'hC3, 8'h83, 1'b1, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++)
      run_cmp(W'($urandom), W'($urandom), i[0], 0);
  endtask

  task automatic test_hold();
    run_cmp(8'h5A, 8'h5B, 1'b0, 10);
    run_cmp(8'h22, 8'h22, 1'b0, 0);
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    bus.P = 8'h01;
    bus.Q = 8'h00;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || {bus.PGTQ, bus.PEQQ, bus.PLTQ} !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_reset in_ready=%b out_valid=%b flags=%b required 1 0 000",
               bus.in_ready, bus.out_valid, {bus.PGTQ, bus.PEQQ, bus.PLTQ});
    end
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL mid_reset_no_result out_valid_cycles=%0d required 0", seen);
    end
    rst_n = 1'b1;
    run_cmp(8'h01, 8'h00, 1'b0, 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_hold();
    test_reset_mid();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left=%0d required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
